// File: rtl/lsu_mem_port.sv
// Load/store unit memory port: decodes size/alignment, drives a single-beat memory
// request, waits for ack with a bounded timeout, and aligns and extends load data.
module lsu_mem_port #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  input  logic        MemRW,
  input  logic [1:0]  S_Sel,
  input  logic [1:0]  L_Sel,
  input  logic        L_sign,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        req_ready,
  output logic        stall,
  output logic [31:0] rdata,
  output logic        rdata_valid,
  output logic        err,
  output logic        mem_en,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [29:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
);

  localparam int unsigned CntW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;

  state_e state_q, state_d;

  logic [CntW-1:0] cnt_q;
  logic            we_q;
  logic [1:0]      size_q;
  logic            zext_q;
  logic [1:0]      addr_lo_q;
  logic [29:0]     mem_addr_q;
  logic [3:0]      be_q;
  logic [31:0]     wdata_q;
  logic            mem_en_q;
  logic [31:0]     rdata_q;
  logic            rdata_valid_q;
  logic            err_q;

  logic [1:0]  req_size;
  logic        req_aligned;
  logic [3:0]  req_be;
  logic [31:0] req_wdata;
  logic        accept;
  logic        start;
  logic        in_access;
  logic        timeout_hit;
  logic [31:0] shifted;
  logic [31:0] load_data;

  // Request decode: size 11 never aligns, so it always takes the error path.
  always_comb begin
    req_size    = MemRW ? S_Sel : L_Sel;
    req_aligned = 1'b0;
    req_be      = 4'b0000;
    req_wdata   = wdata;
    unique case (req_size)
      2'b00: begin
        req_aligned = 1'b1;
        req_be      = 4'b0001 << addr[1:0];
        req_wdata   = {4{wdata[7:0]}};
      end
      2'b01: begin
        req_aligned = ~addr[0];
        req_be      = addr[1] ? 4'b1100 : 4'b0011;
        req_wdata   = {2{wdata[15:0]}};
      end
      2'b10: begin
        req_aligned = (addr[1:0] == 2'b00);
        req_be      = 4'b1111;
        req_wdata   = wdata;
      end
      2'b11: begin
        req_aligned = 1'b0;
      end
    endcase
  end

  always_comb begin
    accept      = (state_q == StIdle) && req_valid;
    start       = accept && req_aligned;
    in_access   = (state_q == StAccess);
    // A same-cycle ack wins over the timeout.
    timeout_hit = in_access && !mem_ack && (cnt_q == CntW'(TIMEOUT - 1));
  end

  // Load alignment: bring the addressed lane down to bit 0, then extend.
  always_comb begin
    shifted   = mem_rdata >> {addr_lo_q, 3'b000};
    load_data = shifted;
    case (size_q)
      2'b00:   load_data = {{24{~zext_q & shifted[7]}}, shifted[7:0]};
      2'b01:   load_data = {{16{~zext_q & shifted[15]}}, shifted[15:0]};
      default: load_data = shifted;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (start) state_d = StAccess;
      end
      StAccess: begin
        if (mem_ack || timeout_hit) state_d = StDone;
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Output logic
  always_comb begin
    req_ready   = (state_q == StIdle);
    stall       = (req_valid && (state_q == StIdle)) || (state_q == StAccess);
    rdata       = rdata_q;
    rdata_valid = rdata_valid_q;
    err         = err_q;
    mem_en      = mem_en_q;
    mem_we      = we_q;
    mem_be      = be_q;
    mem_addr    = mem_addr_q;
    mem_wdata   = wdata_q;
  end

  // Request latch, wait counter and load result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q         <= '0;
      we_q          <= 1'b0;
      size_q        <= 2'b00;
      zext_q        <= 1'b0;
      addr_lo_q     <= 2'b00;
      mem_addr_q    <= '0;
      be_q          <= 4'b0000;
      wdata_q       <= '0;
      mem_en_q      <= 1'b0;
      rdata_q       <= '0;
      rdata_valid_q <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      rdata_valid_q <= 1'b0;
      err_q         <= 1'b0;
      if (accept) begin
        we_q       <= MemRW;
        size_q     <= req_size;
        zext_q     <= L_sign;
        addr_lo_q  <= addr[1:0];
        mem_addr_q <= addr[31:2];
        be_q       <= req_be;
        wdata_q    <= req_wdata;
        cnt_q      <= '0;
        mem_en_q   <= req_aligned;
        err_q      <= ~req_aligned;
      end
      if (in_access) begin
        if (mem_ack) begin
          mem_en_q <= 1'b0;
          if (!we_q) begin
            rdata_q       <= load_data;
            rdata_valid_q <= 1'b1;
          end
        end else if (timeout_hit) begin
          mem_en_q <= 1'b0;
          err_q    <= 1'b1;
          if (!we_q) rdata_q <= '0;
        end else begin
          cnt_q <= cnt_q + CntW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_lsu_mem_port.sv
// Scoreboard bench for lsu_mem_port: stimulus queues expected memory requests and
// responses; two negedge monitors pop and compare when the DUT presents them.
module tb_lsu_mem_port;

  localparam int unsigned TIMEOUT = 15;

  typedef struct {
    logic        err;
    logic        vld;
    logic        chk_rd;
    logic [31:0] rdata;
    int          cyc;
  } rsp_t;

  typedef struct {
    logic        we;
    logic [3:0]  be;
    logic [29:0] addr;
    logic [31:0] wdata;
    logic        chk_wd;
  } req_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        MemRW = 1'b0;
  logic [1:0]  S_Sel = 2'b00;
  logic [1:0]  L_Sel = 2'b00;
  logic        L_sign = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic        req_ready;
  logic        stall;
  logic [31:0] rdata;
  logic        rdata_valid;
  logic        err;
  logic        mem_en;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [29:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        mem_ack = 1'b0;

  int   n_tests = 0;
  int   n_fail = 0;
  int   cyc = 0;
  rsp_t rsp_q[$];
  req_t req_q[$];

  lsu_mem_port #(.TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .MemRW      (MemRW),
    .S_Sel      (S_Sel),
    .L_Sel      (L_Sel),
    .L_sign     (L_sign),
    .addr       (addr),
    .wdata      (wdata),
    .req_ready  (req_ready),
    .stall      (stall),
    .rdata      (rdata),
    .rdata_valid(rdata_valid),
    .err        (err),
    .mem_en     (mem_en),
    .mem_we     (mem_we),
    .mem_be     (mem_be),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ack    (mem_ack)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
    end
  endtask

  // Response monitor
  always @(negedge clk) begin
    rsp_t e;
    if (rst_n && (rdata_valid || err)) begin
      if (rsp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_rsp: got vld=%0b err=%0b rdata=0x%08h, required none",
                 rdata_valid, err, rdata);
      end else begin
        e = rsp_q.pop_front();
        check("rsp_err", {31'b0, err}, {31'b0, e.err});
        check("rsp_vld", {31'b0, rdata_valid}, {31'b0, e.vld});
        if (e.chk_rd) check("rsp_rdata", rdata, e.rdata);
        check("rsp_cycle", 32'(cyc), 32'(e.cyc));
        check("rsp_stall", {31'b0, stall}, 32'h0);
      end
    end
  end

  // Memory-side monitor: pops on each new request, holds it for the whole access.
  logic men_prev = 1'b0;
  logic cur_ok = 1'b0;
  req_t cur;
  always @(negedge clk) begin
    if (mem_en) begin
      if (!men_prev) begin
        if (req_q.size() == 0) begin
          n_tests++;
          n_fail++;
          cur_ok = 1'b0;
          $display("FAIL unexpected_mem_en: got mem_en=1 addr=0x%08h, required mem_en=0",
                   mem_addr);
        end else begin
          cur    = req_q.pop_front();
          cur_ok = 1'b1;
        end
      end
      if (cur_ok) begin
        check("mem_we", {31'b0, mem_we}, {31'b0, cur.we});
        check("mem_be", {28'b0, mem_be}, {28'b0, cur.be});
        check("mem_addr", {2'b0, mem_addr}, {2'b0, cur.addr});
        if (cur.chk_wd) check("mem_wdata", mem_wdata, cur.wdata);
      end
    end
    men_prev = mem_en;
  end

  task automatic wait_idle();
    int n = 0;
    while (!req_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("ready_before_issue", {31'b0, req_ready}, 32'h1);
  endtask

  // ack_dly: >=0 ack after that many extra cycles, -1 never ack, -2 request is misaligned.
  task automatic issue(input logic rw, input logic [1:0] sz, input logic lsign,
                       input logic [31:0] a, input logic [31:0] wd, input int ack_dly,
                       input logic [31:0] rd, input logic exp_acc, input req_t xr,
                       input logic exp_rsp, input rsp_t xs);
    rsp_t s;
    wait_idle();
    s     = xs;
    s.cyc = cyc + xs.cyc;
    if (exp_acc) req_q.push_back(xr);
    if (exp_rsp) rsp_q.push_back(s);
    req_valid = 1'b1;
    MemRW     = rw;
    S_Sel     = rw ? sz : 2'b00;
    L_Sel     = rw ? 2'b00 : sz;
    L_sign    = lsign;
    addr      = a;
    wdata     = wd;
    #1;
    check("stall_on_req", {31'b0, stall}, 32'h1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    if (ack_dly == -2) begin
      check("misaligned_ready", {31'b0, req_ready}, 32'h1);
      check("misaligned_no_en", {31'b0, mem_en}, 32'h0);
      @(posedge clk); #1;
    end else begin
      check("access_mem_en", {31'b0, mem_en}, 32'h1);
      if (ack_dly >= 0) begin
        for (int i = 0; i < ack_dly; i++) begin
          mem_rdata = $urandom;
          @(posedge clk); #1;
        end
        mem_ack   = 1'b1;
        mem_rdata = rd;
        @(posedge clk); #1;
        mem_ack   = 1'b0;
        mem_rdata = $urandom;
      end else begin
        for (int i = 0; i < int'(TIMEOUT); i++) begin
          mem_rdata = $urandom;
          @(posedge clk); #1;
        end
      end
      check("done_not_ready", {31'b0, req_ready}, 32'h0);
      check("done_no_en", {31'b0, mem_en}, 32'h0);
      if (rw) check("store_no_rvalid", {31'b0, rdata_valid}, 32'h0);
      @(posedge clk); #1;
    end
  endtask

  task automatic do_load(input logic [1:0] sz, input logic lsign, input logic [31:0] a,
                         input int dly, input logic [31:0] rd, input logic [3:0] be,
                         input logic [31:0] exp_rd);
    issue(1'b0, sz, lsign, a, 32'h0, dly, rd, 1'b1, req_t'{1'b0, be, a[31:2], 32'h0, 1'b0},
          1'b1, rsp_t'{1'b0, 1'b1, 1'b1, exp_rd, dly + 2});
  endtask

  task automatic do_store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd,
                          input logic [3:0] be, input logic [31:0] exp_wd);
    issue(1'b1, sz, 1'b0, a, wd, 0, 32'h0, 1'b1, req_t'{1'b1, be, a[31:2], exp_wd, 1'b1},
          1'b0, rsp_t'{1'b0, 1'b0, 1'b0, 32'h0, 0});
  endtask

  task automatic do_bad(input logic rw, input logic [1:0] sz, input logic [31:0] a);
    issue(rw, sz, 1'b0, a, 32'h0, -2, 32'h0, 1'b0, req_t'{1'b0, 4'h0, 30'h0, 32'h0, 1'b0},
          1'b1, rsp_t'{1'b1, 1'b0, 1'b0, 32'h0, 1});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish by 100us, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #3;
    check("rst_ready", {31'b0, req_ready}, 32'h1);
    check("rst_stall", {31'b0, stall}, 32'h0);
    check("rst_mem_en", {31'b0, mem_en}, 32'h0);
    check("rst_rdata", rdata, 32'h0);
    check("rst_mem_be", {28'b0, mem_be}, 32'h0);
    check("rst_mem_addr", {2'b0, mem_addr}, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    do_load(2'b00, 1'b0, 32'h0000_0103, 0, 32'h80FF_0000, 4'b1000, 32'hFFFF_FF80);
    do_load(2'b01, 1'b1, 32'h0000_0102, 0, 32'h8001_1234, 4'b1100, 32'h0000_8001);
    do_store(2'b00, 32'h0000_0201, 32'h1234_56AB, 4'b0010, 32'hABAB_ABAB);
    check("rdata_hold", rdata, 32'h0000_8001);
    do_bad(1'b1, 2'b10, 32'h0000_0202);
    do_load(2'b10, 1'b0, 32'h0000_0100, 3, 32'hDEAD_BEEF, 4'b1111, 32'hDEAD_BEEF);
    do_load(2'b01, 1'b0, 32'h0000_0106, 0, 32'hF00D_1234, 4'b1100, 32'hFFFF_F00D);
    do_load(2'b00, 1'b1, 32'h0000_0100, 1, 32'h1234_56F0, 4'b0001, 32'h0000_00F0);
    do_store(2'b01, 32'h0000_0302, 32'hAAAA_BEEF, 4'b1100, 32'hBEEF_BEEF);
    do_bad(1'b0, 2'b11, 32'h0000_0000);
    do_bad(1'b0, 2'b01, 32'h0000_0101);

    // Stray ack while idle must do nothing.
    mem_ack   = 1'b1;
    mem_rdata = 32'h5555_5555;
    repeat (2) @(posedge clk);
    #1;
    mem_ack = 1'b0;
    check("idle_ack_ready", {31'b0, req_ready}, 32'h1);
    check("idle_ack_rdata", rdata, 32'h0000_00F0);

    issue(1'b0, 2'b10, 1'b0, 32'h0000_0104, 32'h0, -1, 32'h0, 1'b1,
          req_t'{1'b0, 4'b1111, 30'h41, 32'h0, 1'b0}, 1'b1,
          rsp_t'{1'b1, 1'b0, 1'b1, 32'h0, int'(TIMEOUT) + 1});

    do_load(2'b00, 1'b0, 32'h0000_0102, 0, 32'h007F_0000, 4'b0100, 32'h0000_007F);

    // Reset in the middle of an access.
    wait_idle();
    req_q.push_back(req_t'{1'b0, 4'b1111, 30'h4, 32'h0, 1'b0});
    req_valid = 1'b1;
    MemRW     = 1'b0;
    L_Sel     = 2'b10;
    S_Sel     = 2'b00;
    addr      = 32'h0000_0010;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("pre_rst_mem_en", {31'b0, mem_en}, 32'h1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_mem_en", {31'b0, mem_en}, 32'h0);
    check("mid_rst_mem_be", {28'b0, mem_be}, 32'h0);
    check("mid_rst_mem_addr", {2'b0, mem_addr}, 32'h0);
    check("mid_rst_rdata", rdata, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("post_rst_ready", {31'b0, req_ready}, 32'h1);
    check("post_rst_stall", {31'b0, stall}, 32'h0);
    check("post_rst_en", {31'b0, mem_en}, 32'h0);
    check("post_rst_rdata", rdata, 32'h0);
    check("post_rst_wdata", mem_wdata, 32'h0);

    do_load(2'b10, 1'b0, 32'h0000_0008, 1, 32'h1357_9BDF, 4'b1111, 32'h1357_9BDF);

    repeat (3) @(posedge clk);
    #1;
    check("rsp_queue_drained", 32'(rsp_q.size()), 32'h0);
    check("req_queue_drained", 32'(req_q.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/lsu_mem_port.md
LSU_MEM_PORT -- requirements
Module: lsu_mem_port

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, named `clk` and `rst_n`.
REQ-002 Parameter TIMEOUT, default 15: maximum number of cycles to wait for `mem_ack` before aborting.
REQ-003 `clk`  in  1  rising-edge clock.
REQ-004 `rst_n`  in  1  asynchronous active-low reset.
REQ-005 `req_valid`  in  1  datapath presents a load or store.
REQ-006 `MemRW`  in  1  1 = store, 0 = load.
REQ-007 `S_Sel`  in  2  store size: 00 byte, 01 half, 10 word, 11 reserved.
REQ-008 `L_Sel`  in  2  load size, same encoding as `S_Sel`.
REQ-009 `L_sign`  in  1  1 = zero-extend the load, 0 = sign-extend the load.
REQ-010 `addr`  in  32  byte address, taken from the ALU output.
REQ-011 `wdata`  in  32  store data (rs2).
REQ-012 `req_ready`  out  1  block idle and able to accept a request.
REQ-013 `stall`  out  1  hold PC and pipeline.
REQ-014 `rdata`  out  32  aligned, extended load result.
REQ-015 `rdata_valid`  out  1  one-cycle pulse when `rdata` is valid.
REQ-016 `err`  out  1  one-cycle pulse on misaligned access, reserved size, or timeout.
REQ-017 `mem_en`  out  1  memory request.
REQ-018 `mem_we`  out  1  memory write.
REQ-019 `mem_be`  out  4  byte enables.
REQ-020 `mem_addr`  out  30  word address, equal to `addr[31:2]`.
REQ-021 `mem_wdata`  out  32  lane-replicated store data.
REQ-022 `mem_rdata`  in  32  memory read word.
REQ-023 `mem_ack`  in  1  memory completion; valid only while `mem_en`=1.

Function
REQ-024 FSM states SHALL be IDLE, ACCESS and DONE.
- `req_ready`=1 only in IDLE.
- `stall` = (`req_valid` & IDLE) | ACCESS.
REQ-025 In IDLE with `req_valid`=1, the block SHALL latch `MemRW`, size, `L_sign`, `addr[1:0]`, `mem_addr`, `mem_be` and `mem_wdata`.
- Aligned access: go to ACCESS next cycle.
- Misaligned access: stay in IDLE, pulse `err`, and assert no `mem_en`.
REQ-026 Alignment rule SHALL be:
- half requires `addr[0]`=0;
- word requires `addr[1:0]`=00;
- size 11 SHALL always be treated as misaligned.
REQ-027 `mem_be` SHALL be:
- byte: 0001 shifted left by `addr[1:0]`;
- half: 0011 shifted left by `addr[1]`\*2;
- word: 1111.
`mem_we` SHALL equal the latched `MemRW`.
REQ-028 `mem_wdata` SHALL be:
- byte: `wdata[7:0]` replicated 4 times;
- half: `wdata[15:0]` replicated 2 times;
- word: `wdata`.
REQ-029 In ACCESS, `mem_en`=1 and all memory outputs SHALL hold stable until `mem_ack`.
- On `mem_ack`, go to DONE.
- A load SHALL capture `mem_rdata` in the same cycle.
REQ-030 A wait counter SHALL clear on entry to ACCESS and increment each ACCESS cycle without `mem_ack`.
- When the counter reaches TIMEOUT, go to DONE and pulse `err`.
- `rdata` SHALL be 0 and no `rdata_valid` SHALL be asserted in that case.
- `mem_ack` in the same cycle as the timeout SHALL take priority over the timeout.
REQ-031 In DONE, the block SHALL:
- pulse `rdata_valid` for loads only;
- drive `stall`=0;
- return to IDLE next cycle.
A request arriving in DONE SHALL be ignored until IDLE.
REQ-032 The load result SHALL be formed by selecting the byte or half by the latched `addr[1:0]`, then extending to 32 bits per `L_sign`.
- `rdata` SHALL hold its value until the next load completes.
REQ-033 Latency, aligned access, `mem_ack` on the first ACCESS cycle: request accepted at cycle 0, ACCESS at cycle 1, DONE with `rdata_valid` at cycle 2.
REQ-034 `mem_ack` outside ACCESS SHALL be ignored.
REQ-035 `req_valid` deasserting during ACCESS SHALL NOT abort the transaction.

Reset
REQ-036 When `rst_n` is low, the block SHALL asynchronously force the following, independent of clock:
- FSM state = IDLE;
- counter = 0;
- `rdata` = 0;
- `rdata_valid`, `err`, `mem_en`, `mem_we` = 0;
- `mem_be`, `mem_addr`, `mem_wdata` = 0.
REQ-037 Reset asserted during ACCESS SHALL drop `mem_en` immediately.
- After release, the block SHALL be in IDLE with `req_ready`=1, with no `rdata_valid` or `err` pulse.

Verification
REQ-038 Signed byte load: LB, `addr`=0x103, `L_sign`=0, `mem_rdata`=0x80FF_0000, ack on the first cycle -> `mem_be`=1000, `rdata`=0xFFFF_FF80, `rdata_valid` at cycle 2.
REQ-039 Unsigned half load: LHU, `addr`=0x102, `L_sign`=1, `mem_rdata`=0x8001_1234 -> `mem_be`=1100, `rdata`=0x0000_8001.
REQ-040 Byte store: SB, `addr`=0x201, `wdata`=0x1234_56AB -> `mem_we`=1, `mem_be`=0010, `mem_wdata`=0xABAB_ABAB, `mem_addr`=0x80, no `rdata_valid`.
REQ-041 Misaligned word: SW to `addr`=0x202 -> `err` pulse, `mem_en` never asserted, `req_ready`=1 next cycle.
REQ-042 Timeout: LW with `mem_ack` held low -> `err` pulse after 15 ACCESS cycles, `rdata_valid`=0, return to IDLE.
REQ-043 Reset mid-access: LW held in ACCESS, `rst_n` pulsed low -> `mem_en`=0 immediately, and IDLE with all outputs 0 after release.
